// File: rtl/clk_div.sv
// rtl/clk_div.sv - integer clock divider with combinational bypass
// Low phase lasts N>>1 reference cycles and high phase the remainder, so odd ratios run high-heavy.
module clk_div #(
    parameter int DIVIDED_RATIO_WIDTH = 4
) (
    input  logic                           i_ref_clk,
    input  logic                           i_rst_n,
    input  logic                           i_clk_en,
    input  logic [DIVIDED_RATIO_WIDTH-1:0] i_div_ratio,
    output logic                           o_div_clk
);

    localparam int W = DIVIDED_RATIO_WIDTH;

    logic [W-1:0] r_cnt;
    logic         r_div;
    logic         w_active;
    logic [W-1:0] w_half;
    logic [W-1:0] w_len;
    logic [W:0]   w_cnt_inc;

    assign w_active  = i_clk_en && (i_div_ratio >= W'(2));
    assign w_half    = i_div_ratio >> 1;
    assign w_len     = r_div ? (i_div_ratio - w_half) : w_half;
    // One extra bit so the increment cannot wrap at the maximum ratio.
    assign w_cnt_inc = {1'b0, r_cnt} + (W+1)'(1);

    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n || !w_active) begin
            r_cnt <= '0;
            r_div <= 1'b0;
        end else if (w_cnt_inc >= {1'b0, w_len}) begin
            // >= rather than == lets a shrunken ratio wrap immediately.
            r_cnt <= '0;
            r_div <= ~r_div;
        end else begin
            r_cnt <= w_cnt_inc[W-1:0];
        end
    end

    assign o_div_clk = w_active ? r_div : i_ref_clk;

endmodule

// File: tb/tb_clk_div.sv
// tb/tb_clk_div.sv - scoreboard bench for clk_div
`timescale 1ns/1ps
module tb_clk_div;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] ratio = 4'd0;
    logic       div_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int    phase;
        logic  exp;
        string tag;
    } ent_t;

    ent_t sb[$];

    localparam int PH_HI  = 0;
    localparam int PH_LO  = 1;
    localparam int PH_PRE = 2;

    clk_div #(.DIVIDED_RATIO_WIDTH(4)) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_clk_en   (en),
        .i_div_ratio(ratio),
        .o_div_clk  (div_clk)
    );

    always #5 clk = ~clk;

    task automatic sample(input int ph);
        ent_t e;
        if (sb.size() != 0 && sb[0].phase == ph) begin
            e = sb.pop_front();
            checks++;
            if (div_clk !== e.exp) begin
                errors++;
                $display("FAIL %s phase=%0d t=%0t: o_div_clk=%b expected=%b",
                         e.tag, ph, $time, div_clk, e.exp);
            end
        end
    endtask

    // Samples: 2ns after rise (clk high), 1ns after fall (clk low), 1ns before next rise.
    initial begin
        forever begin
            @(posedge clk);
            #2 sample(PH_HI);
            #4 sample(PH_LO);
            #3 sample(PH_PRE);
        end
    end

    task automatic push(input int ph, input logic v, input string tag);
        ent_t e;
        e.phase = ph;
        e.exp   = v;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    // Inputs change 2ns after a falling edge and hold through the next rising edge.
    task automatic cyc(input logic r, input logic e, input logic [3:0] n,
                       input logic eh, input logic el, input string tag);
        @(negedge clk);
        #2;
        rst_n = r;
        en    = e;
        ratio = n;
        push(PH_HI, eh, tag);
        push(PH_LO, el, tag);
    endtask

    task automatic cyc_pre(input logic r, input logic e, input logic [3:0] n,
                           input logic ep, input logic eh, input logic el,
                           input string tag);
        @(negedge clk);
        #2;
        rst_n = r;
        en    = e;
        ratio = n;
        push(PH_PRE, ep, {tag, "_pre"});
        push(PH_HI, eh, tag);
        push(PH_LO, el, tag);
    endtask

    task automatic bypass(input logic r, input logic e, input logic [3:0] n,
                          input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) cyc(r, e, n, 1'b1, 1'b0, tag);
    endtask

    // pat holds the hand-derived divided level after each rising edge.
    task automatic run_pat(input logic [3:0] n, input string pat, input string tag);
        logic v;
        for (int i = 0; i < pat.len(); i++) begin
            v = (pat.getc(i) == "1");
            cyc(1'b1, 1'b1, n, v, v, tag);
        end
    endtask

    initial begin
        bypass(1'b0, 1'b0, 4'd4, 3, "rst_bypass");
        cyc(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, "rst_active_low");
        bypass(1'b1, 1'b0, 4'd2, 2, "dis_bypass");
        run_pat(4'd2, "101010", "n2");

        cyc(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, "rst_pulse");
        run_pat(4'd4, "011001100110011001100", "n4");

        bypass(1'b1, 1'b0, 4'd3, 1, "clr3");
        run_pat(4'd3, "110110110", "n3");
        bypass(1'b1, 1'b0, 4'd5, 1, "clr5");
        run_pat(4'd5, "011100111001110", "n5");
        bypass(1'b1, 1'b0, 4'd15, 1, "clr15");
        run_pat(4'd15, "00000011111111000000011111111", "n15");

        bypass(1'b1, 1'b1, 4'd0, 4, "n0_bypass");
        bypass(1'b1, 1'b1, 4'd1, 4, "n1_bypass");

        run_pat(4'd4, "011", "pre_drop");
        cyc_pre(1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, "en_drop");
        bypass(1'b1, 1'b0, 4'd4, 1, "dropped");
        run_pat(4'd4, "0110", "reenable");

        bypass(1'b1, 1'b0, 4'd8, 1, "clr8");
        run_pat(4'd8, "000", "n8");
        run_pat(4'd2, "1010", "n8_to_n2");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
